// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
// Picks one LDQ head or committed SDQ head per idle cycle and pops it.
// Issues it to the cache as a single-outstanding valid/ready request.
// Returns load data as a writeback tagged with the LDQ index.
// Speculative loads are squashed on flush; committed stores always complete.
module lsu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LDQ_IDX_W  = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 ld_vld_i,
  input  logic [ADDR_W-1:0]    ld_addr_i,
  input  logic [LDQ_IDX_W-1:0] ld_idx_i,
  output logic                 ld_issue_en_o,
  input  logic                 st_vld_i,
  input  logic [ADDR_W-1:0]    st_addr_i,
  input  logic [DATA_W-1:0]    st_data_i,
  input  logic [DATA_W/8-1:0]  st_be_i,
  output logic                 st_issue_en_o,
  output logic                 mem_req_vld_o,
  input  logic                 mem_req_rdy_i,
  output logic                 mem_req_we_o,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  output logic [DATA_W-1:0]    mem_req_wdata_o,
  output logic [DATA_W/8-1:0]  mem_req_be_o,
  input  logic                 mem_rsp_vld_i,
  input  logic [DATA_W-1:0]    mem_rsp_data_i,
  output logic                 ld_wb_vld_o,
  output logic [LDQ_IDX_W-1:0] ld_wb_idx_o,
  output logic [DATA_W-1:0]    ld_wb_data_o,
  output logic                 busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  state_e                 state_q,       state_d;
  logic [CNT_W-1:0]       starve_cnt_q,  starve_cnt_d;
  logic                   squash_q,      squash_d;
  logic                   req_we_q,      req_we_d;
  logic [ADDR_W-1:0]      req_addr_q,    req_addr_d;
  logic [DATA_W-1:0]      req_wdata_q,   req_wdata_d;
  logic [BE_W-1:0]        req_be_q,      req_be_d;
  logic [LDQ_IDX_W-1:0]   req_idx_q,     req_idx_d;
  logic                   wb_vld_q,      wb_vld_d;
  logic [LDQ_IDX_W-1:0]   wb_idx_q,      wb_idx_d;
  logic [DATA_W-1:0]      wb_data_q,     wb_data_d;

  logic st_grant;
  logic ld_grant;

  // Grant decision in IDLE: stores win when loads are absent, flushed, or the store has starved.
  always_comb begin
    st_grant = 1'b0;
    ld_grant = 1'b0;
    if (rst_i && (state_q == S_IDLE)) begin
      if (st_vld_i && (!ld_vld_i || flush_i || (starve_cnt_q == STARVE_CNT_MAX))) begin
        st_grant = 1'b1;
      end else if (ld_vld_i && !flush_i) begin
        ld_grant = 1'b1;
      end else begin
        st_grant = 1'b0;
        ld_grant = 1'b0;
      end
    end else begin
      st_grant = 1'b0;
      ld_grant = 1'b0;
    end
  end

  // Next-state, request capture, starvation counter, squash and writeback generation.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    squash_d     = squash_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_be_d     = req_be_q;
    req_idx_d    = req_idx_q;
    wb_vld_d     = 1'b0;
    wb_idx_d     = wb_idx_q;
    wb_data_d    = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (st_grant) begin
          req_we_d     = 1'b1;
          req_addr_d   = st_addr_i;
          req_wdata_d  = st_data_i;
          req_be_d     = st_be_i;
          req_idx_d    = '0;
          starve_cnt_d = '0;
          state_d      = S_REQ;
        end else if (ld_grant) begin
          req_we_d    = 1'b0;
          req_addr_d  = ld_addr_i;
          req_wdata_d = '0;
          req_be_d    = '1;
          req_idx_d   = ld_idx_i;
          state_d     = S_REQ;
          // A waiting store lost this round; count it, saturating.
          if (st_vld_i && (starve_cnt_q < STARVE_CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        if (mem_req_rdy_i) begin
          if (req_we_q) begin
            state_d = S_IDLE;
          end else begin
            // Accept beats a same-cycle flush: the response must still be drained.
            squash_d = flush_i;
            state_d  = S_WAIT_RSP;
          end
        end else if (flush_i && !req_we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WAIT_RSP: begin
        if (mem_rsp_vld_i) begin
          state_d  = S_IDLE;
          squash_d = 1'b0;
          if (!squash_q && !flush_i) begin
            wb_vld_d  = 1'b1;
            wb_idx_d  = req_idx_q;
            wb_data_d = mem_rsp_data_i;
          end else begin
            wb_vld_d = 1'b0;
          end
        end else if (flush_i) begin
          squash_d = 1'b1;
        end else begin
          squash_d = squash_q;
        end
      end

      default: begin
        state_d  = S_IDLE;
        squash_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      squash_q     <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
      req_idx_q    <= '0;
      wb_vld_q     <= 1'b0;
      wb_idx_q     <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      squash_q     <= squash_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_be_q     <= req_be_d;
      req_idx_q    <= req_idx_d;
      wb_vld_q     <= wb_vld_d;
      wb_idx_q     <= wb_idx_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign ld_issue_en_o   = ld_grant;
  assign st_issue_en_o   = st_grant;
  assign mem_req_vld_o   = (state_q == S_REQ);
  assign mem_req_we_o    = req_we_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_be_o    = req_be_q;
  assign ld_wb_vld_o     = wb_vld_q;
  assign ld_wb_idx_o     = wb_idx_q;
  assign ld_wb_data_o    = wb_data_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed testbench for lsu_mem_arbiter.
module tb_lsu_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        ld_vld_i;
  logic [31:0] ld_addr_i;
  logic [2:0]  ld_idx_i;
  logic        ld_issue_en_o;
  logic        st_vld_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_be_i;
  logic        st_issue_en_o;
  logic        mem_req_vld_o;
  logic        mem_req_rdy_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_rsp_vld_i;
  logic [31:0] mem_rsp_data_i;
  logic        ld_wb_vld_o;
  logic [2:0]  ld_wb_idx_o;
  logic [31:0] ld_wb_data_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  lsu_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LDQ_IDX_W(3), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ld_vld_i(ld_vld_i), .ld_addr_i(ld_addr_i), .ld_idx_i(ld_idx_i),
    .ld_issue_en_o(ld_issue_en_o),
    .st_vld_i(st_vld_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_be_i(st_be_i), .st_issue_en_o(st_issue_en_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
    .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_data_i(mem_rsp_data_i),
    .ld_wb_vld_o(ld_wb_vld_o), .ld_wb_idx_o(ld_wb_idx_o),
    .ld_wb_data_o(ld_wb_data_o), .busy_o(busy_o)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_st;
    rst_i = 1'b0; flush_i = 1'b0;
    ld_vld_i = 1'b0; ld_addr_i = 32'h0; ld_idx_i = 3'd0;
    st_vld_i = 1'b0; st_addr_i = 32'h0; st_data_i = 32'h0; st_be_i = 4'h0;
    mem_req_rdy_i = 1'b0; mem_rsp_vld_i = 1'b0; mem_rsp_data_i = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req_vld", 64'(mem_req_vld_o), 64'h0);
    chk("rst_busy",    64'(busy_o),        64'h0);
    chk("rst_wb_vld",  64'(ld_wb_vld_o),   64'h0);
    chk("rst_addr",    64'(mem_req_addr_o), 64'h0);
    chk("rst_be",      64'(mem_req_be_o),  64'h0);
    rst_i = 1'b1;
    tick();

    // 1. Load only
    ld_vld_i = 1'b1; ld_idx_i = 3'd5; ld_addr_i = 32'h100; mem_req_rdy_i = 1'b1;
    #1;
    chk("t1_ld_issue", 64'(ld_issue_en_o), 64'h1);
    chk("t1_st_issue", 64'(st_issue_en_o), 64'h0);
    tick();
    ld_vld_i = 1'b0;
    chk("t1_req_vld",  64'(mem_req_vld_o),  64'h1);
    chk("t1_req_we",   64'(mem_req_we_o),   64'h0);
    chk("t1_req_be",   64'(mem_req_be_o),   64'hF);
    chk("t1_req_addr", 64'(mem_req_addr_o), 64'h100);
    chk("t1_ld_issue_once", 64'(ld_issue_en_o), 64'h0);
    tick();
    chk("t1_wait_vld", 64'(mem_req_vld_o), 64'h0);
    chk("t1_wait_busy", 64'(busy_o), 64'h1);
    tick();
    mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'hDEADBEEF;
    tick();
    mem_rsp_vld_i = 1'b0;
    chk("t1_wb_vld",  64'(ld_wb_vld_o),  64'h1);
    chk("t1_wb_idx",  64'(ld_wb_idx_o),  64'h5);
    chk("t1_wb_data", 64'(ld_wb_data_o), 64'hDEADBEEF);
    tick();
    chk("t1_wb_pulse", 64'(ld_wb_vld_o), 64'h0);
    chk("t1_idle",     64'(busy_o),      64'h0);

    // 2. Store only, rdy low for 3 cycles
    st_vld_i = 1'b1; st_addr_i = 32'h200; st_data_i = 32'h12345678; st_be_i = 4'h3;
    mem_req_rdy_i = 1'b0;
    #1;
    chk("t2_st_issue", 64'(st_issue_en_o), 64'h1);
    chk("t2_ld_issue", 64'(ld_issue_en_o), 64'h0);
    tick();
    st_vld_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_vld",   64'(mem_req_vld_o),   64'h1);
      chk("t2_req_we",    64'(mem_req_we_o),    64'h1);
      chk("t2_req_addr",  64'(mem_req_addr_o),  64'h200);
      chk("t2_req_wdata", 64'(mem_req_wdata_o), 64'h12345678);
      chk("t2_req_be",    64'(mem_req_be_o),    64'h3);
      tick();
    end
    mem_req_rdy_i = 1'b1;
    #1;
    chk("t2_req_vld_acc", 64'(mem_req_vld_o), 64'h1);
    tick();
    chk("t2_idle",    64'(busy_o),      64'h0);
    chk("t2_no_wb",   64'(ld_wb_vld_o), 64'h0);
    chk("t2_vld_low", 64'(mem_req_vld_o), 64'h0);

    // 3. Starvation: four loads, then a forced store, then loads again
    ld_vld_i = 1'b1; ld_idx_i = 3'd3; ld_addr_i = 32'h180;
    st_vld_i = 1'b1; st_addr_i = 32'h280; st_data_i = 32'h0BADF00D; st_be_i = 4'hF;
    mem_req_rdy_i = 1'b1; mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'hA5A50000;
    #1;
    for (int g = 0; g < 6; g++) begin
      exp_st = (g == 4);
      chk("t3_ld_issue", 64'(ld_issue_en_o), 64'(!exp_st));
      chk("t3_st_issue", 64'(st_issue_en_o), 64'(exp_st));
      tick();
      chk("t3_req_we", 64'(mem_req_we_o), 64'(exp_st));
      tick();
      if (!exp_st) begin
        chk("t3_wait_busy", 64'(busy_o), 64'h1);
        tick();
        chk("t3_wb_vld", 64'(ld_wb_vld_o), 64'h1);
        chk("t3_wb_idx", 64'(ld_wb_idx_o), 64'h3);
      end else begin
        chk("t3_st_done", 64'(busy_o), 64'h0);
        chk("t3_st_no_wb", 64'(ld_wb_vld_o), 64'h0);
      end
    end
    ld_vld_i = 1'b0; st_vld_i = 1'b0; mem_rsp_vld_i = 1'b0;
    tick();

    // 4. Flush in WAIT_RSP
    ld_vld_i = 1'b1; ld_idx_i = 3'd2; ld_addr_i = 32'h300; mem_req_rdy_i = 1'b1;
    #1;
    chk("t4_ld_issue", 64'(ld_issue_en_o), 64'h1);
    tick();
    ld_vld_i = 1'b0;
    chk("t4_req_vld", 64'(mem_req_vld_o), 64'h1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'h11111111;
    tick();
    mem_rsp_vld_i = 1'b0;
    chk("t4_no_wb", 64'(ld_wb_vld_o), 64'h0);
    chk("t4_idle",  64'(busy_o),      64'h0);
    tick();
    chk("t4_no_wb2", 64'(ld_wb_vld_o), 64'h0);
    ld_vld_i = 1'b1; ld_idx_i = 3'd6; ld_addr_i = 32'h400;
    #1;
    chk("t4_next_issue", 64'(ld_issue_en_o), 64'h1);
    tick();
    ld_vld_i = 1'b0;
    chk("t4_next_addr", 64'(mem_req_addr_o), 64'h400);
    tick();
    mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'h22222222;
    tick();
    mem_rsp_vld_i = 1'b0;
    chk("t4_next_wb_vld",  64'(ld_wb_vld_o),  64'h1);
    chk("t4_next_wb_idx",  64'(ld_wb_idx_o),  64'h6);
    chk("t4_next_wb_data", 64'(ld_wb_data_o), 64'h22222222);
    tick();

    // 5a. Flush in REQ drops an unaccepted load
    ld_vld_i = 1'b1; ld_idx_i = 3'd1; ld_addr_i = 32'h500; mem_req_rdy_i = 1'b0;
    #1;
    chk("t5a_ld_issue", 64'(ld_issue_en_o), 64'h1);
    tick();
    ld_vld_i = 1'b0;
    chk("t5a_req_vld", 64'(mem_req_vld_o), 64'h1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5a_dropped", 64'(mem_req_vld_o), 64'h0);
    chk("t5a_idle",    64'(busy_o),        64'h0);

    // 5b. Flush in REQ does not drop a store
    st_vld_i = 1'b1; st_addr_i = 32'h600; st_data_i = 32'hCAFEF00D; st_be_i = 4'hC;
    #1;
    chk("t5b_st_issue", 64'(st_issue_en_o), 64'h1);
    tick();
    st_vld_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5b_req_vld",   64'(mem_req_vld_o),   64'h1);
    chk("t5b_req_addr",  64'(mem_req_addr_o),  64'h600);
    chk("t5b_req_wdata", 64'(mem_req_wdata_o), 64'hCAFEF00D);
    mem_req_rdy_i = 1'b1;
    tick();
    chk("t5b_done", 64'(busy_o), 64'h0);

    // 5c. Flush in IDLE: no load grant; store still wins
    ld_vld_i = 1'b1; ld_idx_i = 3'd0; ld_addr_i = 32'h540; flush_i = 1'b1;
    #1;
    chk("t5c_no_ld_issue", 64'(ld_issue_en_o), 64'h0);
    tick();
    chk("t5c_stay_idle", 64'(busy_o), 64'h0);
    st_vld_i = 1'b1; st_addr_i = 32'h640; st_be_i = 4'h1;
    #1;
    chk("t5c_st_issue", 64'(st_issue_en_o), 64'h1);
    chk("t5c_ld_blocked", 64'(ld_issue_en_o), 64'h0);
    tick();
    ld_vld_i = 1'b0; st_vld_i = 1'b0; flush_i = 1'b0;
    chk("t5c_req_we", 64'(mem_req_we_o), 64'h1);
    chk("t5c_req_be", 64'(mem_req_be_o), 64'h1);
    tick();
    chk("t5c_done", 64'(busy_o), 64'h0);

    // 5d. Flush and accept in the same cycle: accept wins, response squashed
    ld_vld_i = 1'b1; ld_idx_i = 3'd4; ld_addr_i = 32'h700;
    #1;
    tick();
    ld_vld_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5d_wait_busy", 64'(busy_o), 64'h1);
    chk("t5d_req_low",   64'(mem_req_vld_o), 64'h0);
    mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'h44444444;
    tick();
    mem_rsp_vld_i = 1'b0;
    chk("t5d_no_wb", 64'(ld_wb_vld_o), 64'h0);
    chk("t5d_idle",  64'(busy_o),      64'h0);

    // 6. Reset during WAIT_RSP
    ld_vld_i = 1'b1; ld_idx_i = 3'd7; ld_addr_i = 32'h800;
    #1;
    tick();
    ld_vld_i = 1'b0;
    tick();
    chk("t6_wait_busy", 64'(busy_o), 64'h1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("t6_busy",    64'(busy_o),         64'h0);
    chk("t6_req_vld", 64'(mem_req_vld_o),  64'h0);
    chk("t6_wb_vld",  64'(ld_wb_vld_o),    64'h0);
    chk("t6_addr",    64'(mem_req_addr_o), 64'h0);
    chk("t6_be",      64'(mem_req_be_o),   64'h0);
    chk("t6_issue",   64'(ld_issue_en_o),  64'h0);
    mem_rsp_vld_i = 1'b1; mem_rsp_data_i = 32'h33333333;
    tick();
    mem_rsp_vld_i = 1'b0;
    chk("t6_late_rsp", 64'(ld_wb_vld_o), 64'h0);
    tick();
    chk("t6_late_rsp2", 64'(ld_wb_vld_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
